data_bus_ctrl: RTL

- Data-side memory subsystem attached directly to the single-cycle core's data bus (data_addr / data_out / data_in / data_write).
- Holds word-addressed data RAM plus three memory-mapped registers:
  - a byte-wide transmit FIFO that drains over a valid/ready stream to the console;
  - a status register;
  - a free-running cycle counter.
- Reads are combinational so the core completes LW in one cycle. Writes commit on the rising clock edge.

---
 rtl/data_bus_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/data_bus_ctrl.sv
// Data-side bus slave for the single-cycle core: word RAM plus TX FIFO, STATUS and CYCLES registers.
// Reads are combinational; all state commits on the rising clock edge.
module data_bus_ctrl #(
  parameter int unsigned MEM_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  input  logic        data_write,
  output logic [31:0] data_in,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   mem_q [MEM_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   cycles_q, cycles_d;

  logic          ram_hit, txdata_hit, status_hit, cycles_hit;
  logic [AW-1:0] ram_idx;
  logic          push, push_ok, pop, full, empty;
  logic [4:0]    count_ext;
  logic [31:0]   status;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^data_addr[1:0];

  assign ram_hit    = (data_addr[31:AW+2] == '0);
  assign ram_idx    = data_addr[AW+1:2];
  assign txdata_hit = (data_addr[31:2] == 30'h2000_0000);
  assign status_hit = (data_addr[31:2] == 30'h2000_0001);
  assign cycles_hit = (data_addr[31:2] == 30'h2000_0002);

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign tx_valid  = ~empty;
  assign tx_data   = fifo_q[rd_ptr_q];
  // Acceptance is judged on the start-of-cycle count, so a same-cycle pop never frees a full FIFO.
  assign push      = data_write & txdata_hit;
  assign push_ok   = push & ~full;
  assign pop       = tx_valid & tx_ready;
  assign count_ext = 5'(count_q);
  assign status    = {23'b0, count_ext, 1'b0, ovf_q, empty, full};

  always_comb begin
    data_in = '0;
    if (ram_hit) begin
      data_in = mem_q[ram_idx];
    end else if (status_hit) begin
      data_in = status;
    end else if (cycles_hit) begin
      data_in = cycles_q;
    end
  end

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    ovf_d    = ovf_q;
    if (push && full) begin
      ovf_d = 1'b1;
    end else if (data_write && status_hit) begin
      ovf_d = 1'b0;
    end
    cycles_d = (data_write && cycles_hit) ? '0 : cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      cycles_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      cycles_q <= cycles_d;
    end
  end

  // Storage arrays carry no reset; RAM survives reset and stale FIFO slots are unreachable.
  always_ff @(posedge clk) begin
    if (data_write && ram_hit) begin
      mem_q[ram_idx] <= data_out;
    end
    if (push_ok && rst) begin
      fifo_q[wr_ptr_q] <= data_out[7:0];
    end
  end

endmodule
